sb_reg_responder: RTL and testbench

//  Sideband target-side responder. It sits between SB_RX (request side) and SB_TX (completion side) on the 100MHz domain.
//  It pulls received SB_msg_t requests, services register reads and writes against a local 64-bit register file, and

---
 rtl/sb_reg_responder.sv | 197 +++++++++++++++++++
 tb/tb_sb_reg_responder.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sb_reg_responder.sv
// Sideband target-side register responder: accepts SB_RX requests, services reads and writes
// against a local 64-bit register file, and returns completions to SB_TX.

package SB_codex_pkg;

    typedef enum logic [4:0] {
        MemRead_32b          = 5'h00,
        MemWrite_32b         = 5'h01,
        DMSRegRead_32b       = 5'h02,
        DMSRegWrite_32b      = 5'h03,
        ConfigRead_32b       = 5'h04,
        ConfigWrite_32b      = 5'h05,
        MemRead_64b          = 5'h08,
        MemWrite_64b         = 5'h09,
        DMSRegRead_64b       = 5'h0A,
        DMSRegWrite_64b      = 5'h0B,
        ConfigRead_64b       = 5'h0C,
        ConfigWrite_64b      = 5'h0D,
        Completion_no_Data   = 5'h10,
        Completion_32b       = 5'h11,
        Message_without_Data = 5'h12,
        Completion_64b       = 5'h19,
        Message_with_Data    = 5'h1B
    } SB_opcode_t;

    typedef struct packed {
        SB_opcode_t  opcode;
        logic [2:0]  srcid;
        logic [2:0]  dstid;
        logic [4:0]  tag;
        logic [7:0]  be;
        logic        cr;
        logic [23:0] addr;
        logic [7:0]  msg_num;
        logic [15:0] msg_info;
    } SB_msg_t;

    function automatic SB_msg_t reset_SB_msg();
        SB_msg_t m;
        m = '0;
        return m;
    endfunction

endpackage

module sb_reg_responder
    import SB_codex_pkg::*;
#(
    parameter int REG_DEPTH = 8
) (
    input  logic        clk_100MHz,
    input  logic        reset,
    input  logic        rx_valid_i,
    input  SB_msg_t     rx_msg_i,
    input  logic [63:0] rx_data_i,
    output logic        rx_req_o,
    input  logic        tx_next_i,
    output logic        tx_valid_o,
    output SB_msg_t     tx_msg_o,
    output logic [63:0] tx_data_o,
    output logic        evt_valid_o,
    output logic [7:0]  evt_msg_num_o,
    output logic [15:0] evt_info_o
);

    localparam int IDX_W = $clog2(REG_DEPTH);

    typedef enum logic [1:0] {IDLE, EXEC, SEND} state_t;

    state_t            state, state_next;
    SB_msg_t           req_q;
    logic [63:0]       req_data_q;
    logic [63:0]       regs [REG_DEPTH];

    logic              accept;
    logic              is_read, is_write, is_wide, is_event, is_ur, completes;
    logic [IDX_W-1:0]  idx;
    logic [7:0]        write_mask;
    logic [63:0]       write_data;
    logic [63:0]       read_data;
    SB_msg_t           cpl_msg;
    logic [63:0]       cpl_data;

    assign accept = rx_valid_i && rx_req_o;
    assign idx    = req_q.addr[3 +: IDX_W];
    assign is_ur  = ((req_q.addr >> (3 + IDX_W)) != '0) || (is_wide && req_q.addr[2]);
    assign completes = is_read || (is_write && req_q.cr);

    always_comb begin
        is_read  = 1'b0;
        is_write = 1'b0;
        is_wide  = 1'b0;
        is_event = 1'b0;
        case (req_q.opcode)
            MemRead_32b, ConfigRead_32b:   is_read = 1'b1;
            MemWrite_32b, ConfigWrite_32b: is_write = 1'b1;
            MemRead_64b, ConfigRead_64b: begin
                is_read = 1'b1;
                is_wide = 1'b1;
            end
            MemWrite_64b, ConfigWrite_64b: begin
                is_write = 1'b1;
                is_wide  = 1'b1;
            end
            Message_without_Data:          is_event = 1'b1;
            default: ;
        endcase
    end

    // 32b accesses steer the low four byte enables onto whichever half addr[2] selects
    always_comb begin
        write_mask = req_q.be;
        write_data = req_data_q;
        if (!is_wide) begin
            write_data = {req_data_q[31:0], req_data_q[31:0]};
            write_mask = req_q.addr[2] ? {req_q.be[3:0], 4'b0000} : {4'b0000, req_q.be[3:0]};
        end
    end

    always_comb begin
        read_data = '0;
        if (!is_ur) begin
            if (is_wide)
                read_data = regs[idx];
            else if (req_q.addr[2])
                read_data = {32'd0, regs[idx][63:32]};
            else
                read_data = {32'd0, regs[idx][31:0]};
        end
    end

    always_comb begin
        cpl_msg       = reset_SB_msg();
        cpl_msg.srcid = req_q.dstid;
        cpl_msg.dstid = req_q.srcid;
        cpl_msg.tag   = req_q.tag;
        cpl_msg.addr  = req_q.addr;
        cpl_msg.be    = req_q.be;
        cpl_msg.msg_info = {13'd0, 2'b00, is_ur};
        if (is_ur || is_write)
            cpl_msg.opcode = Completion_no_Data;
        else if (is_wide)
            cpl_msg.opcode = Completion_64b;
        else
            cpl_msg.opcode = Completion_32b;
        cpl_data = is_read ? read_data : '0;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = EXEC;
            EXEC:    state_next = completes ? SEND : IDLE;
            SEND:    if (tx_next_i) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign evt_valid_o   = (state == EXEC) && is_event;
    assign evt_msg_num_o = evt_valid_o ? req_q.msg_num : '0;
    assign evt_info_o    = evt_valid_o ? req_q.msg_info : '0;

    // rx_req_o only reasserts one cycle after returning to IDLE, keeping at most one request in flight
    always_ff @(posedge clk_100MHz) begin
        if (!reset) begin
            state      <= IDLE;
            req_q      <= reset_SB_msg();
            req_data_q <= '0;
            rx_req_o   <= 1'b0;
            tx_valid_o <= 1'b0;
            tx_msg_o   <= reset_SB_msg();
            tx_data_o  <= '0;
            for (int i = 0; i < REG_DEPTH; i++)
                regs[i] <= '0;
        end else begin
            state      <= state_next;
            rx_req_o   <= (state == IDLE) && !accept;
            tx_valid_o <= (state == SEND) && tx_next_i;
            if (accept) begin
                req_q      <= rx_msg_i;
                req_data_q <= rx_data_i;
            end
            if (state == EXEC) begin
                if (is_write && !is_ur) begin
                    for (int k = 0; k < 8; k++)
                        if (write_mask[k])
                            regs[idx][8*k +: 8] <= write_data[8*k +: 8];
                end
                if (completes) begin
                    tx_msg_o  <= cpl_msg;
                    tx_data_o <= cpl_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_sb_reg_responder.sv
// Testbench for sb_reg_responder: directed register/event/stall/reset scenarios followed by
// randomized requests, all checked against a byte-level register-file model.

module tb_sb_reg_responder;
    import SB_codex_pkg::*;

    localparam int REG_DEPTH = 8;
    localparam logic [7:0] SBINIT_done_req = 8'h95;
    localparam int K_NONE = 0;
    localparam int K_CPL  = 1;
    localparam int K_EVT  = 2;

    logic        clk_100MHz = 1'b0;
    logic        reset;
    logic        rx_valid_i;
    SB_msg_t     rx_msg_i;
    logic [63:0] rx_data_i;
    logic        rx_req_o;
    logic        tx_next_i;
    logic        tx_valid_o;
    SB_msg_t     tx_msg_o;
    logic [63:0] tx_data_o;
    logic        evt_valid_o;
    logic [7:0]  evt_msg_num_o;
    logic [15:0] evt_info_o;

    int checks = 0;
    int errors = 0;
    logic [63:0] model_regs [REG_DEPTH];
    SB_opcode_t  op_list [12];

    sb_reg_responder #(.REG_DEPTH(REG_DEPTH)) dut (
        .clk_100MHz    (clk_100MHz),
        .reset         (reset),
        .rx_valid_i    (rx_valid_i),
        .rx_msg_i      (rx_msg_i),
        .rx_data_i     (rx_data_i),
        .rx_req_o      (rx_req_o),
        .tx_next_i     (tx_next_i),
        .tx_valid_o    (tx_valid_o),
        .tx_msg_o      (tx_msg_o),
        .tx_data_o     (tx_data_o),
        .evt_valid_o   (evt_valid_o),
        .evt_msg_num_o (evt_msg_num_o),
        .evt_info_o    (evt_info_o)
    );

    always #5 clk_100MHz = ~clk_100MHz;

    task automatic tick();
        @(posedge clk_100MHz);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    function automatic SB_msg_t mkMsg(input SB_opcode_t op, input logic [23:0] addr, input logic [7:0] be,
                                      input logic cr, input logic [4:0] tag);
        SB_msg_t m;
        m        = reset_SB_msg();
        m.opcode = op;
        m.srcid  = 3'd1;
        m.dstid  = 3'd2;
        m.addr   = addr;
        m.be     = be;
        m.cr     = cr;
        m.tag    = tag;
        return m;
    endfunction

    // Reference model: byte-addressed register file, decisions taken straight from the access rules
    function automatic void modelRequest(input SB_msg_t m, input logic [63:0] d, output int kind,
                                         output SB_msg_t cm, output logic [63:0] cd);
        bit rd, wr, wide, ur;
        int idx, half;
        kind = K_NONE;
        cm   = reset_SB_msg();
        cd   = '0;
        if (m.opcode == Message_without_Data) begin
            kind = K_EVT;
            return;
        end
        rd   = m.opcode inside {MemRead_32b, ConfigRead_32b, MemRead_64b, ConfigRead_64b};
        wr   = m.opcode inside {MemWrite_32b, ConfigWrite_32b, MemWrite_64b, ConfigWrite_64b};
        wide = m.opcode inside {MemRead_64b, ConfigRead_64b, MemWrite_64b, ConfigWrite_64b};
        if (!rd && !wr) return;
        idx  = int'(m.addr / 8) % REG_DEPTH;
        half = int'(m.addr / 4) % 2;
        ur   = (int'(m.addr) >= REG_DEPTH * 8) || (wide && half == 1);
        if (wr && !ur) begin
            for (int k = 0; k < 8; k++) begin
                if (wide && m.be[k])
                    model_regs[idx][8*k +: 8] = d[8*k +: 8];
                else if (!wide && k < 4 && m.be[k])
                    model_regs[idx][8*(k + 4*half) +: 8] = d[8*k +: 8];
            end
        end
        if (rd || m.cr) begin
            kind = K_CPL;
            if (wr || ur)
                cm.opcode = Completion_no_Data;
            else if (wide)
                cm.opcode = Completion_64b;
            else
                cm.opcode = Completion_32b;
            cm.srcid    = m.dstid;
            cm.dstid    = m.srcid;
            cm.tag      = m.tag;
            cm.addr     = m.addr;
            cm.be       = m.be;
            cm.msg_info = ur ? 16'h0001 : 16'h0000;
            if (rd && !ur)
                cd = wide ? model_regs[idx] : ((model_regs[idx] >> (32 * half)) & 64'hFFFF_FFFF);
        end
    endfunction

    task automatic applyStimulus(input SB_msg_t m, input logic [63:0] d, input int stall, input bit checkLatency);
        int kind, waitc, txPulses, evtPulses, txCycle;
        SB_msg_t cm;
        logic [63:0] cd;
        bit stallQuiet;
        logic reqAfter;
        waitc = 0;
        while (rx_req_o !== 1'b1 && waitc < 20) begin
            tick();
            waitc++;
        end
        checkOutput("rx_req_ready", 128'(rx_req_o), 128'(1'b1));
        if (rx_req_o !== 1'b1) return;
        rx_valid_i = 1'b1;
        rx_msg_i   = m;
        rx_data_i  = d;
        tick();
        rx_valid_i = 1'b0;
        modelRequest(m, d, kind, cm, cd);
        checkOutput("rx_req_drop", 128'(rx_req_o), 128'(1'b0));
        txPulses = 0; evtPulses = 0; txCycle = -1; stallQuiet = 1'b1; reqAfter = 1'bx;
        for (int i = 0; i <= stall + 6; i++) begin
            if (i > 0) begin
                tx_next_i = (i > stall);
                tick();
            end
            if (tx_valid_o === 1'b1) begin
                txPulses++;
                txCycle = i;
                checkOutput("tx_msg", 128'(tx_msg_o), 128'(cm));
                checkOutput("tx_data", 128'(tx_data_o), 128'(cd));
            end
            if (evt_valid_o === 1'b1) begin
                evtPulses++;
                checkOutput("evt_msg_num", 128'(evt_msg_num_o), 128'(m.msg_num));
                checkOutput("evt_info", 128'(evt_info_o), 128'(m.msg_info));
            end
            if (i >= 1 && i <= stall && (tx_valid_o !== 1'b0 || rx_req_o !== 1'b0))
                stallQuiet = 1'b0;
            if (txCycle >= 0 && i == txCycle + 1)
                reqAfter = rx_req_o;
        end
        tx_next_i = 1'b1;
        checkOutput("tx_pulses", 128'(txPulses), 128'(kind == K_CPL));
        checkOutput("evt_pulses", 128'(evtPulses), 128'(kind == K_EVT));
        if (kind == K_CPL && stall > 0)
            checkOutput("stall_quiet", 128'(stallQuiet), 128'(1'b1));
        if (checkLatency && kind == K_CPL) begin
            checkOutput("tx_latency", 128'(txCycle), 128'((stall + 1 > 2) ? stall + 1 : 2));
            checkOutput("rx_req_return", 128'(reqAfter), 128'(1'b1));
        end
    endtask

    initial begin
        SB_msg_t m;
        logic [63:0] d;
        int pulses;
        op_list = '{MemRead_32b, MemWrite_32b, ConfigRead_32b, ConfigWrite_32b, MemRead_64b, MemWrite_64b,
                    ConfigRead_64b, ConfigWrite_64b, Message_without_Data, DMSRegRead_64b,
                    Completion_32b, DMSRegWrite_32b};
        for (int i = 0; i < REG_DEPTH; i++) model_regs[i] = '0;
        reset      = 1'b0;
        rx_valid_i = 1'b0;
        rx_msg_i   = reset_SB_msg();
        rx_data_i  = '0;
        tx_next_i  = 1'b1;

        repeat (3) tick();
        checkOutput("reset_rx_req", 128'(rx_req_o), 128'(1'b0));
        checkOutput("reset_tx_valid", 128'(tx_valid_o), 128'(1'b0));
        reset = 1'b1;
        tick();
        checkOutput("post_reset_rx_req", 128'(rx_req_o), 128'(1'b1));
        checkOutput("post_reset_tx_msg", 128'(tx_msg_o), 128'(reset_SB_msg()));
        checkOutput("post_reset_tx_data", 128'(tx_data_o), 128'(0));
        checkOutput("post_reset_evt", 128'({evt_valid_o, evt_msg_num_o, evt_info_o}), 128'(0));

        $display("[TB] 64b write with completion, then read back");
        applyStimulus(mkMsg(MemWrite_64b, 24'h000008, 8'hFF, 1'b1, 5'd7), 64'hCAFEBABE_DEADBEEF, 0, 1'b1);
        applyStimulus(mkMsg(MemRead_64b, 24'h000008, 8'hFF, 1'b0, 5'd8), 64'h0, 0, 1'b1);

        $display("[TB] 32b partial write to high half without completion, then 32b read");
        applyStimulus(mkMsg(MemWrite_32b, 24'h00000C, 8'h03, 1'b0, 5'd9), 64'h0000_0000_1122_3344, 0, 1'b1);
        applyStimulus(mkMsg(MemRead_32b, 24'h00000C, 8'h0F, 1'b0, 5'd10), 64'h0, 0, 1'b1);

        $display("[TB] unsupported requests: misaligned and out of range");
        applyStimulus(mkMsg(ConfigRead_64b, 24'h000044, 8'hFF, 1'b0, 5'd11), 64'h0, 0, 1'b1);
        applyStimulus(mkMsg(ConfigRead_64b, 24'h123456, 8'hFF, 1'b0, 5'd12), 64'h0, 0, 1'b1);
        applyStimulus(mkMsg(MemWrite_64b, 24'h000100, 8'hFF, 1'b1, 5'd13), 64'h1234_5678_9ABC_DEF0, 0, 1'b1);
        applyStimulus(mkMsg(MemRead_64b, 24'h000008, 8'hFF, 1'b0, 5'd14), 64'h0, 0, 1'b1);

        $display("[TB] message without data event");
        m = mkMsg(Message_without_Data, 24'h0, 8'h00, 1'b0, 5'd0);
        m.msg_num  = SBINIT_done_req;
        m.msg_info = 16'hBEEF;
        applyStimulus(m, 64'h0, 0, 1'b0);

        $display("[TB] completion held off by tx_next_i");
        applyStimulus(mkMsg(MemRead_64b, 24'h000008, 8'hFF, 1'b0, 5'd15), 64'h0, 20, 1'b1);

        $display("[TB] reset while a completion is pending");
        checkOutput("pre_abort_rx_req", 128'(rx_req_o), 128'(1'b1));
        rx_valid_i = 1'b1;
        rx_msg_i   = mkMsg(MemRead_64b, 24'h000008, 8'hFF, 1'b0, 5'd16);
        tx_next_i  = 1'b0;
        tick();
        rx_valid_i = 1'b0;
        pulses = 0;
        repeat (3) begin
            tick();
            if (tx_valid_o) pulses++;
        end
        reset = 1'b0;
        repeat (2) begin
            tick();
            if (tx_valid_o) pulses++;
        end
        reset = 1'b1;
        tx_next_i = 1'b1;
        for (int i = 0; i < REG_DEPTH; i++) model_regs[i] = '0;
        tick();
        checkOutput("abort_rx_req", 128'(rx_req_o), 128'(1'b1));
        repeat (5) begin
            tick();
            if (tx_valid_o) pulses++;
        end
        checkOutput("abort_no_pulse", 128'(pulses), 128'(0));
        applyStimulus(mkMsg(MemRead_64b, 24'h000008, 8'hFF, 1'b0, 5'd17), 64'h0, 0, 1'b1);

        $display("[TB] randomized requests");
        for (int n = 0; n < 80; n++) begin
            m = reset_SB_msg();
            m.opcode   = op_list[$urandom_range(0, 11)];
            m.srcid    = 3'($urandom);
            m.dstid    = 3'($urandom);
            m.tag      = 5'($urandom);
            m.be       = 8'($urandom);
            m.cr       = 1'($urandom);
            m.msg_num  = 8'($urandom);
            m.msg_info = 16'($urandom);
            m.addr     = ($urandom_range(0, 7) == 0) ? 24'($urandom) : 24'($urandom_range(0, REG_DEPTH * 8 - 1));
            d = {$urandom, $urandom};
            applyStimulus(m, d, $urandom_range(0, 3), 1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
